sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master port between two requesters: instruction fetch (port 0) and the EXE/MEM data interface (port 1).
- Sits between the core pipeline and the SRAM-like-to-AXI bridge.
- Tracks outstanding transactions in an in-order ID FIFO and routes each data_ok/rdata back to the requester that issued it.
- Fixed priority: data over inst. The grant is locked until addr_ok.

Parameters:
- OUTSTANDING, 4, maximum in-flight accepted requests (power of 2, 2..16).
- PTR_W, 2, log2(OUTSTANDING).

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req / data_req  in  1  request valid per requester
- inst_wr / data_wr  in  1  write=1, read=0
- inst_size / data_size  in  2  0=byte, 1=half, 2=word
- inst_addr / data_addr  in  32  byte address
- inst_wstrb / data_wstrb  in  4  byte strobes
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted
- inst_data_ok / data_data_ok  out  1  response for this requester
- inst_rdata / data_rdata  out  32  read data
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  1/1/2/32/4/32  downstream request
- m_addr_ok  in  1  downstream accept
- m_data_ok  in  1  downstream response, returned in order
- m_rdata  in  32  downstream read data
- outstanding_cnt  out  PTR_W+1  current in-flight count
- spurious_rsp  out  1  sticky: m_data_ok received with FIFO empty

Behaviour:
- Reset (resetn low, asynchronous):
  - FSM goes to IDLE; FIFO pointers and count clear; spurious_rsp clears.
  - All outputs are 0 while reset is low. This holds even when reset is asserted mid-transaction; in-flight responses arriving afterwards count as spurious.
- FSM states: IDLE, HOLD. Register gnt_id holds 0=inst, 1=data.
- IDLE:
  - If count==OUTSTANDING, m_req=0 and neither addr_ok is asserted.
  - Otherwise select combinationally: data_req wins, else inst_req.
  - m_req=1 with the selected requester's fields.
  - If m_addr_ok is high the same cycle: pulse that requester's addr_ok, push its id, stay in IDLE (zero-bubble back-to-back).
  - Else latch gnt_id and go to HOLD.
- HOLD:
  - m_* is driven from requester gnt_id only; the other requester is stalled even if it has higher priority (no request tearing).
  - On m_addr_ok: pulse gnt_id's addr_ok, push gnt_id, go to IDLE.
  - If the granted requester drops req, return to IDLE with no push. This is a protocol violation, but the arbiter must tolerate it.
- Combinational paths:
  - m_*_addr_ok = m_addr_ok AND granted AND m_req.
  - Non-granted requester's addr_ok=0.
- Response routing:
  - On m_data_ok with FIFO non-empty: pop head id and pulse the matching data_ok in the same cycle.
  - Both rdata outputs are wired to m_rdata. Requesters qualify rdata with their own data_ok.
- Simultaneous push and pop: count unchanged; pointers both advance, wrapping modulo OUTSTANDING.
- Full FIFO: m_req is gated when count==OUTSTANDING, even if a pop occurs the same cycle. The block registers no lookahead and accepts a 1-cycle bubble here.
- m_data_ok with empty FIFO: ignored, no data_ok pulse, spurious_rsp set (sticky until reset).
- Write-response ordering: writes and reads share the FIFO, so a write's data_ok routes like a read's.

Test Plan:
- Single read, no contention:
  - Stimulus: data_req, addr 0x1C000010; m_addr_ok in cycle 0; m_data_ok 3 cycles later with rdata 0xDEADBEEF.
  - Required: data_addr_ok pulses in cycle 0; data_data_ok pulses with rdata 0xDEADBEEF; inst_* stay 0; count goes 0→1→0.
- Priority and lock:
  - Stimulus: inst_req alone with m_addr_ok held low for 2 cycles, so FSM enters HOLD; data_req rises in cycle 1.
  - Required: m_addr stays on the inst address until m_addr_ok; the data request is granted the next cycle.
- Simultaneous arrival:
  - Stimulus: both requesters assert req in the same cycle with m_addr_ok=1 for 2 cycles.
  - Required: data is accepted first, then inst; responses 0x11, 0x22 return to data then inst respectively.
- Full FIFO:
  - Stimulus: issue 4 accepted reads with no m_data_ok; hold inst_req.
  - Required: m_req=0 and count=4; after one m_data_ok, m_req rises the following cycle.
- Wrap and spurious response:
  - Stimulus: run 10 alternating transactions (pointers wrap twice); then send an extra m_data_ok.
  - Required: all ids are routed correctly; the extra m_data_ok produces no data_ok and spurious_rsp=1.
- Reset mid-operation:
  - Stimulus: assert resetn low asynchronously, between clock edges, with 2 transactions outstanding.
  - Required: outputs drop to 0 immediately and count=0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like master port between instruction
// fetch (id 0) and the data interface (id 1). Data has fixed priority, a
// grant that has not yet seen m_addr_ok stays locked, and an in-order ID
// FIFO routes each m_data_ok/m_rdata back to the requester that issued it.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int PTR_W       = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [3:0]       m_wstrb,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic [PTR_W:0]   outstanding_cnt,
  output logic             spurious_rsp
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);

  state_e                 state_q, state_d;
  logic                   gnt_id_q, gnt_id_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic [OUTSTANDING-1:0] id_mem_q, id_mem_d;
  logic                   spurious_q, spurious_d;

  logic full_s;
  logic empty_s;
  logic req_s;
  logic id_s;
  logic push_s;
  logic pop_s;
  logic head_id_s;
  logic req_out_s;

  assign full_s    = (cnt_q == FULL_CNT);
  assign empty_s   = (cnt_q == {(PTR_W + 1){1'b0}});
  assign head_id_s = id_mem_q[rd_ptr_q];
  assign pop_s     = m_data_ok & ~empty_s;

  // Arbitration and grant lock: pick the requester driving m_* and decide push/next state.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    req_s    = 1'b0;
    id_s     = 1'b0;
    push_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data wins whenever it is requesting.
        id_s = data_req;
        if (!full_s && (data_req || inst_req)) begin
          req_s = 1'b1;
          if (m_addr_ok) begin
            push_s = 1'b1;
          end else begin
            gnt_id_d = data_req;
            state_d  = ST_HOLD;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      ST_HOLD: begin
        // Locked to gnt_id: no request tearing even if data arrives meanwhile.
        id_s = gnt_id_q;
        if ((gnt_id_q ? data_req : inst_req) && !full_s) begin
          req_s = 1'b1;
          if (m_addr_ok) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          // Granted requester withdrew: tolerate it and re-arbitrate.
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ID FIFO bookkeeping: push accepted ids, pop on downstream responses.
  always_comb begin
    id_mem_d   = id_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    spurious_d = spurious_q | (m_data_ok & empty_s);
    if (push_s) begin
      id_mem_d[wr_ptr_q] = id_s;
      wr_ptr_d           = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{PTR_W{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  // State, grant and FIFO registers; all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      cnt_q      <= {(PTR_W + 1){1'b0}};
      id_mem_q   <= {OUTSTANDING{1'b0}};
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      id_mem_q   <= id_mem_d;
      spurious_q <= spurious_d;
    end
  end

  // Every combinational output is forced low while reset is asserted.
  assign req_out_s    = resetn & req_s;
  assign m_req        = req_out_s;
  assign m_wr         = req_out_s & (id_s ? data_wr : inst_wr);
  assign m_size       = req_out_s ? (id_s ? data_size  : inst_size)  : 2'b00;
  assign m_addr       = req_out_s ? (id_s ? data_addr  : inst_addr)  : 32'h0000_0000;
  assign m_wstrb      = req_out_s ? (id_s ? data_wstrb : inst_wstrb) : 4'h0;
  assign m_wdata      = req_out_s ? (id_s ? data_wdata : inst_wdata) : 32'h0000_0000;

  assign inst_addr_ok = req_out_s & m_addr_ok & ~id_s;
  assign data_addr_ok = req_out_s & m_addr_ok &  id_s;

  assign inst_data_ok = resetn & pop_s & ~head_id_s;
  assign data_data_ok = resetn & pop_s &  head_id_s;
  assign inst_rdata   = resetn ? m_rdata : 32'h0000_0000;
  assign data_rdata   = resetn ? m_rdata : 32'h0000_0000;

  assign outstanding_cnt = cnt_q;
  assign spurious_rsp    = spurious_q;

endmodule
